// File: rtl/loss_feeder.sv
`timescale 1ns/1ps
// loss_feeder: buffers one batch of Y targets written by the host, then pairs
// each activation H coming out of the systolic array with its matching Y and
// hands the pair (plus the latched 2/N scale) to the MSE gradient stage.
//
// Handshake: h_ready_out is high exactly while the block is in RUN. An H is
// accepted on any rising edge where h_valid_in && h_ready_out. valid_out
// follows an accepted H by one cycle and is never held waiting on a consumer
// (the gradient stage always accepts). An h_valid_in seen while h_ready_out
// is low is dropped and flagged on the sticky err_drop.
module loss_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [AW:0]   cfg_batch_size,
  input  logic [15:0]   cfg_inv2,
  input  logic          y_wr_en,
  input  logic [15:0]   y_wr_data,
  input  logic          h_valid_in,
  input  logic [15:0]   h_in,
  output logic          h_ready_out,
  output logic [15:0]   H_out,
  output logic [15:0]   Y_out,
  output logic          valid_out,
  output logic [15:0]   inv_batch_size_times_two_out,
  output logic          batch_done,
  output logic          busy,
  output logic          err_drop
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // state is left as a named signal so checkers can bind to it directly
  state_t state, state_nxt;

  logic [AW:0]   n_reg;
  logic [AW:0]   n_clamped;
  logic [AW:0]   n_last;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   y_mem [DEPTH];

  logic cfg_acc;
  logic wr_acc;
  logic h_acc;
  logic last_wr;
  logic last_rd;

  assign cfg_acc = (state == S_IDLE) && cfg_valid;
  assign wr_acc  = (state == S_LOAD) && y_wr_en;
  assign h_acc   = (state == S_RUN)  && h_valid_in;

  assign n_last  = n_reg - (AW+1)'(1);
  assign last_wr = ({1'b0, wr_ptr} == n_last);
  assign last_rd = ({1'b0, rd_ptr} == n_last);

  assign h_ready_out = (state == S_RUN);
  assign busy        = (state != S_IDLE);
  // DONE lasts one cycle, which is the cycle valid_out carries the last pair
  assign batch_done  = (state == S_DONE);

  // Batch size sanitising: 0 means a single sample, oversize saturates at DEPTH
  always_comb begin
    n_clamped = cfg_batch_size;
    if (cfg_batch_size == '0)
      n_clamped = (AW+1)'(1);
    else if (cfg_batch_size > (AW+1)'(DEPTH))
      n_clamped = (AW+1)'(DEPTH);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cfg_valid)           state_nxt = S_LOAD;
      S_LOAD: if (y_wr_en && last_wr)  state_nxt = S_RUN;
      S_RUN:  if (h_valid_in && last_rd) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Y target buffer; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_acc) y_mem[wr_ptr] <= y_wr_data;
  end

  // Batch configuration, pointers and the sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg                        <= '0;
      inv_batch_size_times_two_out <= '0;
      wr_ptr                       <= '0;
      rd_ptr                       <= '0;
      err_drop                     <= 1'b0;
    end else begin
      if (cfg_acc) begin
        n_reg                        <= n_clamped;
        inv_batch_size_times_two_out <= cfg_inv2;
        wr_ptr                       <= '0;
        err_drop                     <= 1'b0;
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (last_wr) rd_ptr <= '0;
      end
      if (h_acc) rd_ptr <= rd_ptr + 1'b1;
      // a dropped sample in the same cycle as a config still leaves the flag set
      if (h_valid_in && (state != S_RUN)) err_drop <= 1'b1;
    end
  end

  // Output pair register: one valid_out per accepted H, data held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      H_out     <= '0;
      Y_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= h_acc;
      if (h_acc) begin
        H_out <= h_in;
        Y_out <= y_mem[rd_ptr];
      end
    end
  end

endmodule
